// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

  localparam int UartDataBits = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } uart_rx_state_t;

endpackage

// File: rtl/uart_clk_div.sv
// rtl/uart_clk_div.sv - free-running bit-period divider with a mid-period mark
module uart_clk_div #(
  parameter int DivMaxVal  = 16,
  parameter int DivMarkPos = 7
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic mark_o
);

  localparam int CntW = $clog2(DivMaxVal);
  localparam logic [CntW-1:0] CntMax  = CntW'(DivMaxVal - 1);
  localparam logic [CntW-1:0] MarkPos = CntW'(DivMarkPos);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      cnt <= '0;
    end else if (enable_i) begin
      cnt <= (cnt == CntMax) ? '0 : cnt + 1'b1;
    end
  end

  assign mark_o = enable_i && (cnt == MarkPos);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver sampling each bit near its centre
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClksPerBit = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rx_i,
  output logic [UartDataBits-1:0] data_o,
  output logic                    valid_o,
  output logic                    frame_err_o,
  output logic                    busy_o
);

  logic                    rx_meta;
  logic                    rx_s;
  logic [1:0]              sync_fill;
  logic                    armed;
  logic                    mark;
  uart_rx_state_t          state;
  logic [2:0]              bit_cnt;
  logic [UartDataBits-1:0] shift_reg;

  // sync_fill marks when rx_s holds a real line sample rather than the reset value;
  // armed then requires one observed high level, so a line caught low by reset is ignored.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      rx_meta   <= rx_i;
      rx_s      <= rx_meta;
      sync_fill <= {sync_fill[0], 1'b1};
      armed     <= armed | (sync_fill[1] & rx_s);
    end
  end

  uart_clk_div #(
    .DivMaxVal (ClksPerBit),
    .DivMarkPos(ClksPerBit / 2 - 1)
  ) u_clk_div (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (state == IDLE),
    .enable_i(state != IDLE),
    .mark_o  (mark)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && !rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (mark) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
        end
        DATA: begin
          if (mark) begin
            shift_reg <= {rx_s, shift_reg[UartDataBits-1:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (mark) begin
            if (rx_s) begin
              data_o  <= shift_reg;
              valid_o <= 1'b1;
              state   <= IDLE;
            end else begin
              frame_err_o <= 1'b1;
              state       <= RECOVER;
            end
          end
        end
        RECOVER: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

  localparam int Cpb = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  int n_checks = 0;
  int n_bad    = 0;

  // Scoreboard records: {is_frame_err, data}; a framing error carries data 0.
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  logic [7:0] last_good = 8'h00;
  int         overlap = 0;
  int         double_pulse = 0;
  logic       prev_v = 1'b0;
  logic       prev_e = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.ClksPerBit(Cpb)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .rx_i       (rx),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always @(negedge clk) begin
    if (valid_o) got_q.push_back({1'b0, data_o});
    if (frame_err_o) got_q.push_back(9'h100);
    if (valid_o && frame_err_o) overlap++;
    if ((valid_o && prev_v) || (frame_err_o && prev_e)) double_pulse++;
    prev_v = valid_o;
    prev_e = frame_err_o;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    rx = 1'b1;
    if (stop) begin
      exp_q.push_back({1'b0, d});
      last_good = d;
    end else begin
      exp_q.push_back(9'h100);
    end
  endtask

  task automatic compare(input string tag);
    repeat (2 * Cpb) @(negedge clk);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_rec%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_data_held"}, data_o, last_good);
    check({tag, "_idle"}, busy_o, 0);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int busy_cycles;
    logic [7:0] d;
    logic stop;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b1);
    compare("a5");

    send_frame(8'h3C, 1'b0);
    send_bit(1'b1);
    compare("3c_bad_stop");

    // Short low glitch must be rejected at the start-bit sample.
    busy_cycles = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) rx = 1'b1;
      @(negedge clk);
      if (busy_o) busy_cycles++;
    end
    check("glitch_busy_rose", busy_cycles > 0, 1);
    check("glitch_busy_short", busy_cycles <= 10, 1);
    compare("glitch");

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    compare("b2b");

    // 0x81 aborted by a one-cycle reset in the middle of bit 4.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h81 >> i));
    rx = 1'b0;
    repeat (Cpb / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_good = 8'h00;
    check("midrst_busy", busy_o, 0);
    check("midrst_data", data_o, 8'h00);
    repeat (Cpb / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(1'b1 & (8'h81 >> i));
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h42, 1'b1);
    compare("midrst");

    // Break: line held low for 30 bit times.
    rx = 1'b0;
    repeat (30 * Cpb) @(negedge clk);
    check("break_busy_held", busy_o, 1);
    rx = 1'b1;
    exp_q.push_back(9'h100);
    compare("break");

    for (int n = 0; n < 24; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, stop);
      if (!stop || $urandom_range(0, 1) == 1) send_bit(1'b1);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    compare("random");

    check("never_overlap", overlap, 0);
    check("single_cycle_pulses", double_pulse, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
